rr_lock_arb: RTL and testbench

Round-robin arbiter with grant locking for sharing one multi-cycle resource among `REQCNT` requesters. A winner keeps the grant until it signals `done_i`, drops its request, or reaches the `MAX_HOLD` cycle limit. It sits between requester request lines and the shared resource's select mux, as the sequencing counterpart to the single-cycle `rr_top` arbiter. It also keeps a sticky worst-case-wait statistic for fairness checks.

---
 rtl/rr_lock_arb_if.sv | 27 ++
 rtl/rr_lock_arb.sv | 120 ++++++++++++
 tb/tb_rr_lock_arb.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/rr_lock_arb_if.sv
// Request/grant bundle between requesters and the round-robin lock arbiter.
// The master side drives requests and releases; the slave side is the arbiter.
interface rr_lock_arb_if #(
    parameter int REQCNT = 16,
    parameter int WAIT_W = 16
);
    localparam int NUM_W = $clog2(REQCNT);

    logic [REQCNT-1:0] req_i;
    logic              done_i;
    logic              clr_stat_i;
    logic [REQCNT-1:0] gnt_o;
    logic [NUM_W-1:0]  gnt_num_o;
    logic              gnt_val_o;
    logic              gnt_new_o;
    logic [WAIT_W-1:0] max_wait_o;

    modport master (
        output req_i, done_i, clr_stat_i,
        input  gnt_o, gnt_num_o, gnt_val_o, gnt_new_o, max_wait_o
    );

    modport slave (
        input  req_i, done_i, clr_stat_i,
        output gnt_o, gnt_num_o, gnt_val_o, gnt_new_o, max_wait_o
    );
endinterface

// File: rtl/rr_lock_arb.sv
// Round-robin arbiter that locks the grant until done, request drop or hold
// limit, plus a sticky worst-case wait statistic for fairness monitoring.
module rr_lock_arb #(
    parameter int REQCNT   = 16,
    parameter int MAX_HOLD = 8,
    parameter int WAIT_W   = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    rr_lock_arb_if.slave bus
);
    localparam int NUM_W  = $clog2(REQCNT);
    localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t            state;
    logic [NUM_W-1:0]  ptr;
    logic [HOLD_W-1:0] hold_cnt;

    logic [NUM_W-1:0]  next_ptr;
    logic [NUM_W-1:0]  search_base;
    logic              release_now;
    logic              win_found;
    logic [NUM_W-1:0]  win_idx;
    logic [NUM_W:0]    cand;

    // On release the search restarts just past the outgoing grantee, in the same cycle.
    always_comb begin
        next_ptr    = (bus.gnt_num_o == NUM_W'(REQCNT - 1)) ? '0 : bus.gnt_num_o + NUM_W'(1);
        release_now = bus.done_i || !bus.req_i[bus.gnt_num_o] ||
                      (hold_cnt == HOLD_W'(MAX_HOLD - 1));
        search_base = (state == GRANT) ? next_ptr : ptr;
        win_found   = 1'b0;
        win_idx     = '0;
        cand        = '0;
        for (int unsigned k = 0; k < REQCNT; k++) begin
            cand = {1'b0, search_base} + (NUM_W + 1)'(k);
            if (cand >= (NUM_W + 1)'(REQCNT))
                cand = cand - (NUM_W + 1)'(REQCNT);
            if (!win_found && bus.req_i[cand[NUM_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[NUM_W-1:0];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= IDLE;
            ptr           <= '0;
            hold_cnt      <= '0;
            bus.gnt_o     <= '0;
            bus.gnt_num_o <= '0;
            bus.gnt_val_o <= 1'b0;
            bus.gnt_new_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_found) begin
                        state         <= GRANT;
                        bus.gnt_o     <= REQCNT'(1) << win_idx;
                        bus.gnt_num_o <= win_idx;
                        bus.gnt_val_o <= 1'b1;
                        bus.gnt_new_o <= 1'b1;
                        hold_cnt      <= '0;
                    end else begin
                        bus.gnt_new_o <= 1'b0;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        ptr <= next_ptr;
                        if (win_found) begin
                            bus.gnt_o     <= REQCNT'(1) << win_idx;
                            bus.gnt_num_o <= win_idx;
                            bus.gnt_new_o <= 1'b1;
                            hold_cnt      <= '0;
                        end else begin
                            state         <= IDLE;
                            bus.gnt_o     <= '0;
                            bus.gnt_val_o <= 1'b0;
                            bus.gnt_new_o <= 1'b0;
                        end
                    end else begin
                        hold_cnt      <= hold_cnt + HOLD_W'(1);
                        bus.gnt_new_o <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic [WAIT_W-1:0] wait_cnt [REQCNT];
    logic [WAIT_W-1:0] run_max  [REQCNT+1];

    assign run_max[0] = '0;

    for (genvar g = 0; g < REQCNT; g++) begin : g_wait
        always_ff @(posedge clk_i) begin
            if (rst_i || bus.clr_stat_i)
                wait_cnt[g] <= '0;
            else if (bus.req_i[g] && !bus.gnt_o[g])
                wait_cnt[g] <= (wait_cnt[g] == '1) ? wait_cnt[g] : wait_cnt[g] + WAIT_W'(1);
            else
                wait_cnt[g] <= '0;
        end

        assign run_max[g+1] = (wait_cnt[g] > run_max[g]) ? wait_cnt[g] : run_max[g];
    end

    // Statistic trails the counters by one cycle since it folds in their registered values.
    always_ff @(posedge clk_i) begin
        if (rst_i || bus.clr_stat_i)
            bus.max_wait_o <= '0;
        else if (run_max[REQCNT] > bus.max_wait_o)
            bus.max_wait_o <= run_max[REQCNT];
    end
endmodule

// File: tb/tb_rr_lock_arb.sv
// Randomised and directed checks of rr_lock_arb against a queue-free
// behavioural model that tracks grantee, grant age and per-requester waits.
module tb_rr_lock_arb;
    localparam int N    = 16;
    localparam int MH   = 8;
    localparam int WW   = 16;
    localparam int WMAX = (1 << WW) - 1;

    int checks   = 0;
    int failures = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rr_lock_arb_if #(.REQCNT(N), .WAIT_W(WW)) bus ();

    rr_lock_arb #(.REQCNT(N), .MAX_HOLD(MH), .WAIT_W(WW)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: grantee index, number of cycles it has held, search origin.
    bit m_on  = 1'b0;
    bit m_val = 1'b0;
    bit m_new = 1'b0;
    int m_idx = 0;
    int m_len = 0;
    int m_ptr = 0;
    int m_max = 0;
    int m_wait [N];
    int nw     [N];
    int mx;
    int w;

    function automatic int pick_from(input int start, input logic [N-1:0] r);
        for (int k = 0; k < N; k++)
            if (r[(start + k) % N]) return (start + k) % N;
        return -1;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_on = 1'b1; m_val = 1'b0; m_new = 1'b0;
            m_idx = 0; m_len = 0; m_ptr = 0; m_max = 0;
            for (int i = 0; i < N; i++) m_wait[i] = 0;
        end else begin
            mx = m_max;
            for (int i = 0; i < N; i++) begin
                if (m_wait[i] > mx) mx = m_wait[i];
                if (bus.clr_stat_i) nw[i] = 0;
                else if (bus.req_i[i] && !(m_val && m_idx == i))
                    nw[i] = (m_wait[i] == WMAX) ? WMAX : m_wait[i] + 1;
                else nw[i] = 0;
            end
            m_max = bus.clr_stat_i ? 0 : mx;
            for (int i = 0; i < N; i++) m_wait[i] = nw[i];

            if (!m_val) begin
                w = pick_from(m_ptr, bus.req_i);
                if (w >= 0) begin m_val = 1'b1; m_idx = w; m_len = 1; m_new = 1'b1; end
                else m_new = 1'b0;
            end else if (bus.done_i || !bus.req_i[m_idx] || m_len == MH) begin
                m_ptr = (m_idx + 1) % N;
                w = pick_from(m_ptr, bus.req_i);
                if (w >= 0) begin m_idx = w; m_len = 1; m_new = 1'b1; end
                else begin m_val = 1'b0; m_new = 1'b0; end
            end else begin
                m_len++;
                m_new = 1'b0;
            end
        end
    end

    logic [N-1:0] exp_gnt;
    always @(negedge clk) begin
        if (m_on) begin
            exp_gnt = m_val ? (N'(1) << m_idx) : '0;
            check("gnt_o",      64'(bus.gnt_o),      64'(exp_gnt));
            check("gnt_num_o",  64'(bus.gnt_num_o),  64'(m_idx));
            check("gnt_val_o",  64'(bus.gnt_val_o),  64'(m_val));
            check("gnt_new_o",  64'(bus.gnt_new_o),  64'(m_new));
            check("max_wait_o", 64'(bus.max_wait_o), 64'(m_max));
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; bus.req_i = '0; bus.done_i = 1'b0; bus.clr_stat_i = 1'b0;
        step();
        rst = 1'b0;
    endtask

    initial begin
        bus.req_i = '0; bus.done_i = 1'b0; bus.clr_stat_i = 1'b0;

        // Single request, released by done in its third grant cycle.
        do_reset();
        check("t1 reset val", 64'(bus.gnt_val_o), 64'd0);
        check("t1 reset gnt", 64'(bus.gnt_o), 64'd0);
        bus.req_i = 16'h0001;
        step();
        check("t1 c1 gnt", 64'(bus.gnt_o), 64'h1);
        check("t1 c1 new", 64'(bus.gnt_new_o), 64'd1);
        step();
        check("t1 c2 new", 64'(bus.gnt_new_o), 64'd0);
        step();
        check("t1 c3 val", 64'(bus.gnt_val_o), 64'd1);
        bus.done_i = 1'b1; bus.req_i = '0;
        step();
        bus.done_i = 1'b0;
        check("t1 c4 val", 64'(bus.gnt_val_o), 64'd0);
        check("t1 c4 num", 64'(bus.gnt_num_o), 64'd0);

        // All requesting, done every cycle: strict rotation with no bubble.
        do_reset();
        bus.req_i = 16'hFFFF; bus.done_i = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            step();
            check("t2 num", 64'(bus.gnt_num_o), 64'((k - 1) % 16));
            check("t2 new", 64'(bus.gnt_new_o), 64'd1);
        end
        bus.done_i = 1'b0;

        // Sole requester hitting the hold limit is re-granted back-to-back.
        do_reset();
        bus.req_i = 16'h0008;
        for (int k = 1; k <= 24; k++) begin
            step();
            check("t3 num", 64'(bus.gnt_num_o), 64'd3);
            check("t3 val", 64'(bus.gnt_val_o), 64'd1);
            check("t3 new", 64'(bus.gnt_new_o), 64'((k == 1 || k == 9 || k == 17) ? 1 : 0));
        end

        // Wrap-around past the top index.
        do_reset();
        bus.req_i = 16'h0200;
        step();
        check("t4 first", 64'(bus.gnt_num_o), 64'd9);
        bus.req_i = 16'h0220; bus.done_i = 1'b1;
        step();
        check("t4 next5", 64'(bus.gnt_num_o), 64'd5);
        do_reset();
        bus.req_i = 16'h0200;
        step();
        bus.req_i = 16'h0221; bus.done_i = 1'b1;
        step();
        check("t4 next0", 64'(bus.gnt_num_o), 64'd0);
        bus.done_i = 1'b0;

        // Worst-case wait: requester 15 first granted in cycle 121.
        do_reset();
        bus.req_i = 16'hFFFF;
        for (int k = 1; k <= 121; k++) step();
        check("t5 num15", 64'(bus.gnt_num_o), 64'd15);
        check("t5 new15", 64'(bus.gnt_new_o), 64'd1);
        step();
        check("t5 max", 64'(bus.max_wait_o), 64'd121);
        for (int k = 0; k < 8; k++) step();
        check("t5 max stable", 64'(bus.max_wait_o), 64'd121);
        bus.clr_stat_i = 1'b1;
        step();
        bus.clr_stat_i = 1'b0;
        check("t5 clr", 64'(bus.max_wait_o), 64'd0);

        // Reset in the fourth cycle of a grant to index 6.
        do_reset();
        bus.req_i = 16'h0040;
        for (int k = 1; k <= 4; k++) begin
            step();
            check("t6 num6", 64'(bus.gnt_num_o), 64'd6);
        end
        rst = 1'b1; bus.req_i = 16'hFFFF; bus.done_i = 1'b1;
        step();
        check("t6 gnt", 64'(bus.gnt_o), 64'd0);
        check("t6 val", 64'(bus.gnt_val_o), 64'd0);
        check("t6 num", 64'(bus.gnt_num_o), 64'd0);
        check("t6 max", 64'(bus.max_wait_o), 64'd0);
        rst = 1'b0; bus.done_i = 1'b0;
        step();
        check("t6 post num", 64'(bus.gnt_num_o), 64'd0);
        check("t6 post val", 64'(bus.gnt_val_o), 64'd1);

        // Random traffic; the per-cycle compare process does the checking.
        for (int k = 0; k < 4000; k++) begin
            rst = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 3))
                    0: bus.req_i = 16'($urandom & $urandom);
                    1: bus.req_i = 16'hFFFF;
                    2: bus.req_i = 16'(1) << $urandom_range(0, N - 1);
                    default: bus.req_i = '0;
                endcase
            end
            bus.done_i     = ($urandom_range(0, 3) == 0);
            bus.clr_stat_i = ($urandom_range(0, 49) == 0);
            step();
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
